// File: rtl/sdram_arbit.sv
// SDRAM channel arbiter: grants refresh/write/read one at a time and muxes the
// granted channel onto registered SDRAM pins. Optional macro SDRAM_ARBIT_RR_EN.
module sdram_arbit #(
  parameter int ADDR_W = 13
) (
  input  logic              arbit_clk,
  input  logic              arbit_rst,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [1:0]        init_bank,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              atref_req,
  input  logic              atref_end,
  input  logic [3:0]        atref_cmd,
  input  logic [1:0]        atref_bank,
  input  logic [ADDR_W-1:0] atref_addr,
  output logic              atref_en,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [1:0]        wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [1:0]        rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic [3:0]        sdram_cmd,
  output logic [1:0]        sdram_bank,
  output logic [ADDR_W-1:0] sdram_addr
);

  localparam logic [3:0] CMD_NOP = 4'b0111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARBIT = 3'd1,
    AREF  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cmd_q, cmd_d;
  logic [1:0]          bank_q, bank_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cke_q;

`ifdef SDRAM_ARBIT_RR_EN
  // 1 = read was granted last; reset value favours write on the first tie
  logic last_rd_q, last_rd_d;

  always_comb begin
    last_rd_d = last_rd_q;
    if (state_q == ARBIT && state_d == WRITE) last_rd_d = 1'b0;
    if (state_q == ARBIT && state_d == READ)  last_rd_d = 1'b1;
  end

  always_ff @(posedge arbit_clk) begin
    if (arbit_rst) last_rd_q <= 1'b1;
    else           last_rd_q <= last_rd_d;
  end
`endif

  always_ff @(posedge arbit_clk) begin
    if (arbit_rst) begin
      state_q <= IDLE;
      cmd_q   <= CMD_NOP;
      bank_q  <= 2'b11;
      addr_q  <= '1;
      cke_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
      cke_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (init_end) state_d = ARBIT;
      ARBIT: begin
        if (atref_req) state_d = AREF;
        else if (wr_req && rd_req) begin
`ifdef SDRAM_ARBIT_RR_EN
          state_d = last_rd_q ? WRITE : READ;
`else
          state_d = WRITE;
`endif
        end
        else if (wr_req) state_d = WRITE;
        else if (rd_req) state_d = READ;
      end
      AREF:  if (atref_end) state_d = ARBIT;
      WRITE: if (wr_end)    state_d = ARBIT;
      READ:  if (rd_end)    state_d = ARBIT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    atref_en = (state_q == AREF);
    wr_en    = (state_q == WRITE);
    rd_en    = (state_q == READ);
    cmd_d    = CMD_NOP;
    bank_d   = 2'b11;
    addr_d   = '1;
    case (state_q)
      IDLE:  begin cmd_d = init_cmd;  bank_d = init_bank;  addr_d = init_addr;  end
      AREF:  begin cmd_d = atref_cmd; bank_d = atref_bank; addr_d = atref_addr; end
      WRITE: begin cmd_d = wr_cmd;    bank_d = wr_bank;    addr_d = wr_addr;    end
      READ:  begin cmd_d = rd_cmd;    bank_d = rd_bank;    addr_d = rd_addr;    end
      default: ;
    endcase
  end

  assign sdram_cke  = cke_q;
  assign sdram_cmd  = cmd_q;
  assign sdram_bank = bank_q;
  assign sdram_addr = addr_q;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit; expected grant order follows SDRAM_ARBIT_RR_EN.
module tb_sdram_arbit;
  localparam int ADDR_W = 13;

  logic              arbit_clk = 1'b0;
  logic              arbit_rst;
  logic              init_end;
  logic [3:0]        init_cmd;
  logic [1:0]        init_bank;
  logic [ADDR_W-1:0] init_addr;
  logic              atref_req, atref_end;
  logic [3:0]        atref_cmd;
  logic [1:0]        atref_bank;
  logic [ADDR_W-1:0] atref_addr;
  logic              atref_en;
  logic              wr_req, wr_end;
  logic [3:0]        wr_cmd;
  logic [1:0]        wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic              rd_req, rd_end;
  logic [3:0]        rd_cmd;
  logic [1:0]        rd_bank;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic              sdram_cke;
  logic [3:0]        sdram_cmd;
  logic [1:0]        sdram_bank;
  logic [ADDR_W-1:0] sdram_addr;

  int n_vec = 0;
  int n_err = 0;

  sdram_arbit #(.ADDR_W(ADDR_W)) dut (
    .arbit_clk(arbit_clk), .arbit_rst(arbit_rst),
    .init_end(init_end), .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr),
    .atref_req(atref_req), .atref_end(atref_end), .atref_cmd(atref_cmd),
    .atref_bank(atref_bank), .atref_addr(atref_addr), .atref_en(atref_en),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_bank(wr_bank),
    .wr_addr(wr_addr), .wr_en(wr_en),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_bank(rd_bank),
    .rd_addr(rd_addr), .rd_en(rd_en),
    .sdram_cke(sdram_cke), .sdram_cmd(sdram_cmd), .sdram_bank(sdram_bank),
    .sdram_addr(sdram_addr)
  );

  always #5 arbit_clk = ~arbit_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are checked 1 ns after the edge
  task automatic tick();
    @(posedge arbit_clk);
    #1;
  endtask

  function automatic logic [2:0] ens();
    return {atref_en, wr_en, rd_en};
  endfunction

  logic [2:0] exp_seq [4];

  initial begin
    arbit_rst = 1'b1; init_end = 1'b0;
    init_cmd = 4'b0010; init_bank = 2'b00; init_addr = 13'h0400;
    atref_req = 0; atref_end = 0; atref_cmd = 4'b0001; atref_bank = 2'b01; atref_addr = 13'h0111;
    wr_req = 0; wr_end = 0; wr_cmd = 4'b0100; wr_bank = 2'b10; wr_addr = 13'h0abc;
    rd_req = 0; rd_end = 0; rd_cmd = 4'b0101; rd_bank = 2'b01; rd_addr = 13'h1234;

    // reset and init
    tick(); tick();
    chk("rst_cmd", 32'(sdram_cmd), 32'h7);
    chk("rst_bank", 32'(sdram_bank), 32'h3);
    chk("rst_addr", 32'(sdram_addr), 32'h1fff);
    chk("rst_cke", 32'(sdram_cke), 32'h1);
    chk("rst_en", 32'(ens()), 32'h0);
    arbit_rst = 1'b0;
    tick();
    chk("init_cmd", 32'(sdram_cmd), 32'h2);
    chk("init_en", 32'(ens()), 32'h0);
    init_end = 1'b1;
    tick(); tick();
    chk("arbit_cmd", 32'(sdram_cmd), 32'h7);
    chk("arbit_bank", 32'(sdram_bank), 32'h3);

    // refresh grant and pin latency
    atref_req = 1'b1;
    tick();
    chk("aref_en", 32'(ens()), 32'h4);
    atref_req = 1'b0;
    tick();
    chk("aref_cmd", 32'(sdram_cmd), 32'h1);
    chk("aref_addr", 32'(sdram_addr), 32'h0111);
    atref_end = 1'b1;
    tick();
    atref_end = 1'b0;
    chk("aref_end", 32'(ens()), 32'h0);

    // all three requesting: refresh, then write, then read, one ARBIT gap each
    atref_req = 1; wr_req = 1; rd_req = 1;
    tick();
    chk("pri_aref", 32'(ens()), 32'h4);
    atref_req = 0; atref_end = 1;
    tick();
    atref_end = 0;
    chk("pri_gap1", 32'(ens()), 32'h0);
    tick();
    chk("pri_wr", 32'(ens()), 32'h2);
    wr_req = 0;
    tick();
    chk("wr_pin_cmd", 32'(sdram_cmd), 32'h4);
    chk("wr_pin_addr", 32'(sdram_addr), 32'h0abc);
    wr_end = 1;
    tick();
    wr_end = 0;
    chk("pri_gap2", 32'(ens()), 32'h0);
    tick();
    chk("pri_rd", 32'(ens()), 32'h1);
    rd_req = 0;
    tick();
    chk("rd_pin_bank", 32'(sdram_bank), 32'h1);
    rd_end = 1;
    tick();
    rd_end = 0;
    chk("pri_gap3", 32'(ens()), 32'h0);

    // refresh arriving during a write waits for wr_end
    wr_req = 1;
    tick();
    chk("rdw_wr", 32'(ens()), 32'h2);
    wr_req = 0; atref_req = 1; rd_end = 1;
    tick();
    rd_end = 0;
    chk("rdw_hold", 32'(ens()), 32'h2);
    wr_end = 1;
    tick();
    wr_end = 0;
    chk("rdw_u1", 32'(ens()), 32'h0);
    tick();
    chk("rdw_u2", 32'(ens()), 32'h4);

    // reset in the middle of refresh
    atref_req = 0;
    tick();
    arbit_rst = 1; init_end = 0;
    tick();
    arbit_rst = 0;
    chk("mrst_en", 32'(ens()), 32'h0);
    chk("mrst_cmd", 32'(sdram_cmd), 32'h7);
    chk("mrst_addr", 32'(sdram_addr), 32'h1fff);
    atref_end = 1;
    tick();
    atref_end = 0;
    chk("mrst_end_ign", 32'(ens()), 32'h0);
    init_end = 1;
    tick();
    chk("mrst_arbit", 32'(ens()), 32'h0);

    // write and read both held; end pulsed 3 cycles after each grant
`ifdef SDRAM_ARBIT_RR_EN
    exp_seq[0] = 3'b010; exp_seq[1] = 3'b001; exp_seq[2] = 3'b010; exp_seq[3] = 3'b001;
`else
    exp_seq[0] = 3'b010; exp_seq[1] = 3'b010; exp_seq[2] = 3'b010; exp_seq[3] = 3'b010;
`endif
    wr_req = 1; rd_req = 1;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk($sformatf("rr_grant%0d", g), 32'(ens()), 32'(exp_seq[g]));
      tick(); tick(); tick();
      if (ens() == 3'b001) rd_end = 1; else wr_end = 1;
      tick();
      wr_end = 0; rd_end = 0;
      chk($sformatf("rr_gap%0d", g), 32'(ens()), 32'h0);
    end
    wr_req = 0; rd_req = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
